// File: rtl/lcu_loader.sv
`timescale 1ns/1ps
// lcu_loader
// Fetches one LCU_W x LCU_H 8-bit luma block from external memory over an
// Avalon-MM pipelined read master and streams it into the on-chip LCU buffer.
// lcu_loaded is a level that feeds an edge-capture PIO, so each completed load
// gives the Nios one fresh rising edge.
//
// Ports
//   clk, reset                  system clock, asynchronous active-high reset
//   start                       one-cycle load request (honoured only when idle)
//   base_addr, stride           byte address of top-left pixel, frame row pitch
//   avm_address, avm_read       Avalon read request (held while stalled)
//   avm_waitrequest             slave stall
//   avm_readdata[31:0]          4 pixels, little-endian
//   avm_readdatavalid           returned word valid (in issue order)
//   buf_wr_en/addr/data         registered write port into the LCU buffer
//   busy                        load in progress
//   lcu_loaded                  high after a completed load until the next start
module lcu_loader #(
  parameter int LCU_W   = 64,
  parameter int LCU_H   = 64,
  parameter int ADDR_W  = 32,
  parameter int MAX_OUT = 4,
  parameter int BUF_AW  = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] stride,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_read,
  input  logic              avm_waitrequest,
  input  logic [31:0]       avm_readdata,
  input  logic              avm_readdatavalid,
  output logic              buf_wr_en,
  output logic [BUF_AW-1:0] buf_wr_addr,
  output logic [31:0]       buf_wr_data,
  output logic              busy,
  output logic              lcu_loaded
);

  localparam int WPR   = LCU_W / 4;
  localparam int TOTAL = WPR * LCU_H;
  localparam int CNT_W = $clog2(TOTAL + 1);
  localparam int COL_W = (WPR > 1) ? $clog2(WPR) : 1;
  localparam int OUT_W = 4;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t            state_reg;
  logic [ADDR_W-1:0] row_base_reg;
  logic [ADDR_W-1:0] stride_reg;
  logic [COL_W-1:0]  col_reg;
  logic [CNT_W-1:0]  issued_reg;
  logic [CNT_W-1:0]  received_reg;
  logic [OUT_W-1:0]  outstanding_reg;

  logic accept;
  logic beat;
  logic col_wrap;
  logic last_issue;
  logic last_beat;

  // The request depends only on registered state, so it (and the address)
  // cannot change while the slave holds waitrequest: nothing advances
  // without an accept, and the outstanding count can only drop meanwhile.
  assign avm_read    = (state_reg == ISSUE) &&
                       (outstanding_reg < OUT_W'(MAX_OUT)) &&
                       (issued_reg < CNT_W'(TOTAL));
  assign avm_address = row_base_reg + (ADDR_W'(col_reg) << 2);

  assign accept     = avm_read && !avm_waitrequest;
  // Beats seen while idle are leftovers from an abandoned load.
  assign beat       = avm_readdatavalid && (state_reg != IDLE);
  assign col_wrap   = (col_reg == COL_W'(WPR - 1));
  assign last_issue = accept && (issued_reg == CNT_W'(TOTAL - 1));
  assign last_beat  = beat && (received_reg == CNT_W'(TOTAL - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg       <= IDLE;
      row_base_reg    <= '0;
      stride_reg      <= '0;
      col_reg         <= '0;
      issued_reg      <= '0;
      received_reg    <= '0;
      outstanding_reg <= '0;
      buf_wr_en       <= 1'b0;
      buf_wr_addr     <= '0;
      buf_wr_data     <= '0;
      busy            <= 1'b0;
      lcu_loaded      <= 1'b0;
    end else begin
      buf_wr_en <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            // Word-align both the origin and the row pitch.
            row_base_reg    <= base_addr & ~ADDR_W'(3);
            stride_reg      <= stride & ~ADDR_W'(3);
            col_reg         <= '0;
            issued_reg      <= '0;
            received_reg    <= '0;
            outstanding_reg <= '0;
            busy            <= 1'b1;
            lcu_loaded      <= 1'b0;
            state_reg       <= ISSUE;
          end
        end
        default: begin
          if (accept) begin
            issued_reg <= issued_reg + 1'b1;
            if (col_wrap) begin
              col_reg      <= '0;
              row_base_reg <= row_base_reg + stride_reg;
            end else begin
              col_reg <= col_reg + 1'b1;
            end
          end
          if (last_issue) begin
            state_reg <= DRAIN;
          end

          if (accept && !beat) begin
            outstanding_reg <= outstanding_reg + 1'b1;
          end else if (!accept && beat) begin
            outstanding_reg <= outstanding_reg - 1'b1;
          end

          if (beat) begin
            buf_wr_en    <= 1'b1;
            buf_wr_addr  <= BUF_AW'(received_reg);
            buf_wr_data  <= avm_readdata;
            received_reg <= received_reg + 1'b1;
          end

          // Completion is flagged alongside the final buffer write.
          if (last_beat) begin
            state_reg  <= IDLE;
            busy       <= 1'b0;
            lcu_loaded <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lcu_loader.sv
`timescale 1ns/1ps
// tb_lcu_loader
// Directed bench for lcu_loader: an Avalon slave model with configurable read
// latency and periodic stalls, a negedge monitor that logs requests, buffer
// writes, outstanding depth and lcu_loaded rising edges, and a linear
// sequence of loads checked against hand-derived addresses and data.
module tb_lcu_loader;

  localparam int TOTAL   = 1024;
  localparam int MAX_OUT = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] base_addr;
  logic [31:0] stride;
  logic [31:0] avm_address;
  logic        avm_read;
  logic        avm_waitrequest = 1'b0;
  logic [31:0] avm_readdata = 32'h0;
  logic        avm_readdatavalid = 1'b0;
  logic        buf_wr_en;
  logic [9:0]  buf_wr_addr;
  logic [31:0] buf_wr_data;
  logic        busy;
  logic        lcu_loaded;

  int checks   = 0;
  int failures = 0;

  lcu_loader #(
    .LCU_W(64), .LCU_H(64), .ADDR_W(32), .MAX_OUT(MAX_OUT), .BUF_AW(10)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .base_addr(base_addr),
    .stride(stride),
    .avm_address(avm_address),
    .avm_read(avm_read),
    .avm_waitrequest(avm_waitrequest),
    .avm_readdata(avm_readdata),
    .avm_readdatavalid(avm_readdatavalid),
    .buf_wr_en(buf_wr_en),
    .buf_wr_addr(buf_wr_addr),
    .buf_wr_data(buf_wr_data),
    .busy(busy),
    .lcu_loaded(lcu_loaded)
  );

  always #5 clk = ~clk;

  // Memory contents: each word is a fixed function of its byte address.
  function automatic logic [31:0] pix(input logic [31:0] a);
    return a ^ 32'hC3A5_0F1E;
  endfunction

  // Expected byte address of the i-th word of the LCU.
  function automatic logic [31:0] exp_addr(input logic [31:0] b, input logic [31:0] s, input int i);
    logic [31:0] row;
    logic [31:0] col;
    row = 32'(i / 16);
    col = 32'(i % 16);
    return {b[31:2], 2'b00} + row * {s[31:2], 2'b00} + 32'd4 * col;
  endfunction

  // ---------------- slave model ----------------
  typedef struct { int due; logic [31:0] data; } beat_t;
  beat_t       rq[$];
  int          cyc = 0;
  int          lat = 2;
  bit          stall_mode = 1'b0;
  logic        acc_s = 1'b0;
  logic [31:0] acc_addr_s = 32'h0;

  always @(posedge clk) begin
    #1;
    if (acc_s) rq.push_back('{due: cyc + lat, data: pix(acc_addr_s)});
    cyc = cyc + 1;
    avm_readdatavalid = 1'b0;
    avm_readdata = 32'h0;
    if (rq.size() > 0 && rq[0].due <= cyc) begin
      avm_readdatavalid = 1'b1;
      avm_readdata = rq[0].data;
      void'(rq.pop_front());
    end
    avm_waitrequest = stall_mode && (cyc % 4 != 0);
  end

  // ---------------- monitor ----------------
  int          load_id = 0;
  int          mon_id = 0;
  int          acc_n = 0;
  int          wr_n = 0;
  int          out_cnt = 0;
  int          max_out = 0;
  int          stall_viol = 0;
  int          edges = 0;
  int          wr_total = 0;
  logic [31:0] acc_log [TOTAL];
  logic [9:0]  wr_addr_log [TOTAL];
  logic [31:0] wr_data_log [TOTAL];
  logic        prev_stall = 1'b0;
  logic [31:0] prev_addr = 32'h0;
  logic        prev_loaded = 1'b0;

  always @(negedge clk) begin
    if (mon_id != load_id) begin
      mon_id = load_id;
      acc_n = 0; wr_n = 0; out_cnt = 0; max_out = 0; stall_viol = 0;
    end
    acc_s = avm_read && !avm_waitrequest;
    acc_addr_s = avm_address;
    if (prev_stall && !(avm_read && avm_address == prev_addr)) stall_viol++;
    prev_stall = avm_read && avm_waitrequest && !reset;
    prev_addr = avm_address;
    if (acc_s) begin
      if (acc_n < TOTAL) acc_log[acc_n] = avm_address;
      acc_n++;
    end
    if (buf_wr_en) begin
      if (wr_n < TOTAL) begin
        wr_addr_log[wr_n] = buf_wr_addr;
        wr_data_log[wr_n] = buf_wr_data;
      end
      wr_n++;
      wr_total++;
    end
    if (busy) begin
      out_cnt = out_cnt + int'(acc_s) - int'(avm_readdatavalid);
      if (out_cnt > max_out) max_out = out_cnt;
    end
    if (lcu_loaded && !prev_loaded) edges++;
    prev_loaded = lcu_loaded;
  end

  // ---------------- helpers ----------------
  logic [31:0] cur_base;
  logic [31:0] cur_stride;
  int          start_cyc;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic kick(input logic [31:0] b, input logic [31:0] s);
    @(posedge clk); #2;
    base_addr = b; stride = s; start = 1'b1;
    cur_base = b; cur_stride = s;
    load_id++;
    start_cyc = cyc;
    @(posedge clk); #2;
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, output int t);
    int n;
    n = 0;
    t = -1;
    while (n < 20000) begin
      @(negedge clk); #1;
      if (lcu_loaded) begin
        t = cyc;
        break;
      end
      n++;
    end
    if (t < 0) check({tag, "_done_timeout"}, 64'(lcu_loaded), 64'(1));
  endtask

  task automatic verify(input string tag);
    bit bad_a, bad_wa, bad_wd;
    logic [31:0] ea;
    bad_a = 0; bad_wa = 0; bad_wd = 0;
    check({tag, "_busy_low"}, 64'(busy), 64'(0));
    check({tag, "_reads_issued"}, 64'(acc_n), 64'(TOTAL));
    check({tag, "_buf_writes"}, 64'(wr_n), 64'(TOTAL));
    for (int i = 0; i < TOTAL; i++) begin
      ea = exp_addr(cur_base, cur_stride, i);
      if (!bad_a) begin
        check($sformatf("%s_addr[%0d]", tag, i), 64'(acc_log[i]), 64'(ea));
        bad_a = (acc_log[i] !== ea);
      end
      if (!bad_wa) begin
        check($sformatf("%s_wr_addr[%0d]", tag, i), 64'(wr_addr_log[i]), 64'(i));
        bad_wa = (wr_addr_log[i] !== 10'(i));
      end
      if (!bad_wd) begin
        check($sformatf("%s_wr_data[%0d]", tag, i), 64'(wr_data_log[i]), 64'(pix(ea)));
        bad_wd = (wr_data_log[i] !== pix(ea));
      end
    end
    $display("load %s base=0x%08h stride=0x%08h reads=%0d writes=%0d max_outstanding=%0d",
             tag, cur_base, cur_stride, acc_n, wr_n, max_out);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_avm_read"}, 64'(avm_read), 64'(0));
    check({tag, "_avm_address"}, 64'(avm_address), 64'(0));
    check({tag, "_buf_wr_en"}, 64'(buf_wr_en), 64'(0));
    check({tag, "_buf_wr_addr"}, 64'(buf_wr_addr), 64'(0));
    check({tag, "_buf_wr_data"}, 64'(buf_wr_data), 64'(0));
    check({tag, "_busy"}, 64'(busy), 64'(0));
    check({tag, "_lcu_loaded"}, 64'(lcu_loaded), 64'(0));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int t;
    int e0;
    int w0;
    int n;
    bit found;

    reset = 1'b1; start = 1'b0; base_addr = 32'h0; stride = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    check_outputs_zero("reset");
    @(posedge clk); #2;
    reset = 1'b0;

    // 1: zero-wait slave, latency 2
    lat = 2; stall_mode = 1'b0;
    e0 = edges;
    kick(32'h1000, 32'h780);
    wait_done("t1", t);
    verify("t1");
    check("t1_first_addr", 64'(acc_log[0]), 64'(32'h1000));
    check("t1_row0_last", 64'(acc_log[15]), 64'(32'h103C));
    check("t1_row1_first", 64'(acc_log[16]), 64'(32'h1780));
    check("t1_last_addr", 64'(acc_log[1023]), 64'(32'h0001_E8BC));
    repeat (5) @(negedge clk);
    #1;
    check("t1_loaded_held", 64'(lcu_loaded), 64'(1));
    check("t1_one_edge", 64'(edges - e0), 64'(1));

    // 2: stall 3 of 4 cycles, latency 10
    lat = 10; stall_mode = 1'b1;
    kick(32'h2000, 32'h800);
    wait_done("t2", t);
    verify("t2");
    check("t2_max_out_le4", 64'(max_out <= MAX_OUT), 64'(1));
    check("t2_stall_stable", 64'(stall_viol), 64'(0));

    // 3: latency 1, accept and valid together every cycle
    lat = 1; stall_mode = 1'b0;
    kick(32'h3000, 32'h780);
    wait_done("t3", t);
    verify("t3");
    check("t3_out_constant", 64'(max_out), 64'(1));
    check("t3_load_cycles", 64'(t - start_cyc), 64'(1026));

    // 4: start ignored mid-load, then a second load after completion
    lat = 2;
    e0 = edges;
    kick(32'h1000, 32'h780);
    n = 0;
    while (cyc < start_cyc + 100 && n < 200) begin
      @(posedge clk); #2;
      n++;
    end
    base_addr = 32'h5000; stride = 32'h100; start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    check("t4_busy_after_ignored", 64'(busy), 64'(1));
    wait_done("t4a", t);
    verify("t4a");
    kick(32'h1000, 32'h780);
    check("t4_loaded_drop", 64'(lcu_loaded), 64'(0));
    check("t4_busy_again", 64'(busy), 64'(1));
    wait_done("t4b", t);
    verify("t4b");
    check("t4_two_edges", 64'(edges - e0), 64'(2));

    // 5: reset in DRAIN with 3 reads still outstanding
    lat = 10; stall_mode = 1'b0;
    kick(32'h1000, 32'h780);
    found = 0;
    n = 0;
    while (!found && n < 20000) begin
      @(negedge clk); #1;
      found = (acc_n == TOTAL) && busy && !avm_read && (rq.size() == 3);
      n++;
    end
    check("t5_drain_reached", 64'(found), 64'(1));
    check("t5_max_out", 64'(max_out), 64'(MAX_OUT));
    w0 = wr_total;
    reset = 1'b1;
    #1;
    check_outputs_zero("t5_reset");
    @(negedge clk); #1;
    reset = 1'b0;
    n = 0;
    while (rq.size() != 0 && n < 100) begin
      @(negedge clk); #1;
      n++;
    end
    repeat (3) @(negedge clk);
    #1;
    check("t5_stray_writes", 64'(wr_total - w0), 64'(0));
    check("t5_idle_busy", 64'(busy), 64'(0));
    check("t5_idle_loaded", 64'(lcu_loaded), 64'(0));
    $display("load t5_abort reads=%0d writes_after_reset=%0d", acc_n, wr_total - w0);
    lat = 2;
    kick(32'h1000, 32'h780);
    wait_done("t5", t);
    verify("t5");

    // 6: unaligned base/stride, then address wrap
    kick(32'h1003, 32'h7FF);
    wait_done("t6", t);
    verify("t6");
    check("t6_first_addr", 64'(acc_log[0]), 64'(32'h1000));
    check("t6_row1_first", 64'(acc_log[16]), 64'(32'h17FC));
    check("t6_last_addr", 64'(acc_log[1023]), 64'(32'h0002_0740));

    kick(32'hFFFF_FFF0, 32'h780);
    wait_done("t7", t);
    verify("t7");
    check("t7_first_addr", 64'(acc_log[0]), 64'(32'hFFFF_FFF0));
    check("t7_wrap_addr", 64'(acc_log[4]), 64'(32'h0000_0000));
    check("t7_row1_first", 64'(acc_log[16]), 64'(32'h0000_0770));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lcu_loader.md
Name: lcu_loader

Overview:
- Fetches one 64x64 8-bit luma LCU from external memory over an Avalon-MM read master and writes it into the on-chip LCU buffer.
- Raises `lcu_loaded` on completion. That signal drives the `lcu_loaded` edge-capture PIO, whose IRQ tells the Nios that the LCU is ready for the Kvazaar search core.
- Sits directly upstream of that PIO. `start`, `base_addr` and `stride` come from control PIOs.

Parameters:
- LCU_W, 64, LCU width in pixels (multiple of 4).
- LCU_H, 64, LCU height in rows.
- ADDR_W, 32, Avalon byte-address width.
- MAX_OUT, 4, maximum outstanding pipelined reads (1..15).
- BUF_AW, 10, buffer word-address width; 2^BUF_AW >= LCU_W*LCU_H/4.

Ports:
- clk, input, 1: system clock.
- reset, input, 1: asynchronous, active-high reset.
- start, input, 1: one-cycle load request.
- base_addr, input, ADDR_W: byte address of LCU top-left pixel.
- stride, input, ADDR_W: byte distance between consecutive frame rows.
- avm_address, output, ADDR_W: read byte address.
- avm_read, output, 1: read request.
- avm_waitrequest, input, 1: slave stall.
- avm_readdata, input, 32: returned word, 4 pixels, little-endian.
- avm_readdatavalid, input, 1: returned word valid.
- buf_wr_en, output, 1: buffer write strobe.
- buf_wr_addr, output, BUF_AW: buffer word address (row*LCU_W/4 + col).
- buf_wr_data, output, 32: buffer write data.
- busy, output, 1: load in progress.
- lcu_loaded, output, 1: level, high after a completed load.

Behaviour:
- Reset values:
  - All outputs 0.
  - FSM = IDLE.
  - Counters, outstanding count and address registers = 0.
- Geometry:
  - WPR = LCU_W/4 words per row.
  - TOTAL = WPR*LCU_H words; default 16 and 1024.
- FSM states: IDLE, ISSUE, DRAIN.
- IDLE:
  - On `start`, latch `base_addr` and `stride` with bits [1:0] forced to 0.
  - Clear `lcu_loaded`, set `busy`, clear issue/receive counters.
  - Next state ISSUE.
- ISSUE:
  - `avm_read` = 1 whenever outstanding < MAX_OUT and issued < TOTAL.
  - `avm_address` = row_base + 4*col.
  - A read is accepted when `avm_read` & ~`avm_waitrequest`. On acceptance: issued+1, col+1.
  - When col wraps at WPR: col = 0, row_base += stride (modulo 2^ADDR_W).
  - `avm_address` and `avm_read` must stay stable while `avm_waitrequest` is high.
  - Go to DRAIN in the cycle the TOTAL-th read is accepted. `avm_read` is 0 from the next cycle.
- Outstanding count:
  - +1 on acceptance, -1 on `avm_readdatavalid`.
  - Both in the same cycle: unchanged.
  - Never exceeds MAX_OUT.
- Receive path (ISSUE and DRAIN):
  - `avm_readdatavalid` produces `buf_wr_en` = 1 one cycle later (registered).
  - `buf_wr_data` = `avm_readdata`; `buf_wr_addr` = received count. Then received+1.
  - Data arrives in issue order; no reordering.
- DRAIN:
  - When received reaches TOTAL (the last valid beat), next cycle: `busy` = 0, `lcu_loaded` = 1, FSM = IDLE.
  - This is the same cycle as the last `buf_wr_en`.
- `lcu_loaded` stays high until the next accepted `start`.
  - It falls for at least one cycle before the next completion, giving the PIO a fresh rising edge per LCU.
- `start` while `busy` is ignored; latched parameters and counters are unchanged.
- `start` in the same cycle as completion is ignored. Software must wait for `lcu_loaded`.
- `avm_readdatavalid` while IDLE (stray beat) is ignored: no buffer write, no counter change.
- Reset mid-load:
  - Immediate return to IDLE with all outputs 0.
  - Outstanding reads are abandoned. Beats arriving after reset deasserts are stray and ignored.
- Address arithmetic wraps modulo 2^ADDR_W; no fault is raised.

Test Plan:
- Zero-wait slave, readdatavalid 2 cycles after accept, `base_addr` = 0x1000, `stride` = 0x780:
  - 1024 reads issued.
  - First row addresses 0x1000..0x103C; row 1 starts at 0x1780; last address 0x1000 + 63*0x780 + 0x3C.
  - `buf_wr_addr` 0..1023 with matching data.
  - `lcu_loaded` rises exactly once.
- Latency and throttling: slave holds `avm_waitrequest` high 3 of every 4 cycles, readdatavalid latency 10:
  - Outstanding count never exceeds 4.
  - Address stable during stall.
  - Completion and data correct.
- Simultaneous accept and valid every cycle (latency 1, no stall):
  - Outstanding count is constant after ramp-up.
  - Total load time = 1024 + latency + 2 cycles ±1.
- `start` pulsed at cycle 100 of an active load:
  - Ignored; addresses continue from the original base.
  - Second `start` after `lcu_loaded`: `lcu_loaded` drops the next cycle and rises again at the end.
  - PIO model sees two edges.
- Reset asserted mid-DRAIN with 3 reads outstanding:
  - All outputs 0 immediately.
  - The 3 late `avm_readdatavalid` beats produce no `buf_wr_en`.
  - A new `start` loads cleanly from `buf_wr_addr` 0.
- `base_addr` = 0x1003, `stride` = 0x7FF:
  - Addresses use 0x1000 and 0x7FC.
  - `base_addr` = 0xFFFFFFF0 wraps to 0x00000000 without error.
